// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   - state_t     : FSM state encoding (also exported on the debug port)
//   - aluop_t     : FSM-to-ALU-decoder operation class
//   - OP_* / F_*  : instruction opcode and funct field values
//   - ALU_*       : alucontrol encodings driven to the datapath ALU
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        BNE     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // opcode field [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // funct field [5:0]
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // alucontrol encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: ALU decoder. Maps the FSM's operation class and the
// instruction funct field to the 3-bit alucontrol code.
//   aluop      in  2  add / sub / decode-from-funct
//   funct      in  6  instruction funct field
//   alucontrol out 3  ALU operation select
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle processor control FSM (Moore, pcEn in the
// branch states additionally depends on zero).
//   FETCH_WAIT  param  extra memory wait cycles held in FETCH (0..7)
//   clk, reset  in     clock; asynchronous active-high reset
//   op, funct   in  6  instruction fields [31:26] / [5:0]
//   zero        in  1  ALU zero flag
//   pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA
//               out 1  datapath controls
//   alusrcB, pcsrc out 2, alucontrol out 3  mux selects / ALU op
//   state       out 4  current FSM state (debug)
// Optional feature: define MC_BNE_EN to add the BNE instruction path.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcEn,
    output logic       IorD,
    output logic       memwrite,
    output logic       IRwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] waitcnt;
    logic       lastfetch;
    aluop_t     aluop;

    logic pcen_raw;
    logic irwrite_raw;
    logic regwrite_raw;
    logic memwrite_raw;

    assign lastfetch = (waitcnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            waitcnt <= '0;
        end else begin
            state_q <= state_d;
            // counts memory wait cycles; returns to 0 as FETCH is left
            if (state_q == FETCH && !lastfetch)
                waitcnt <= waitcnt + 3'd1;
            else
                waitcnt <= '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pcen_raw     = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        IorD         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrcA      = 1'b0;
        alusrcB      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = ALUOP_ADD;

        case (state_q)
            FETCH: begin
                alusrcB = 2'b01;
                if (lastfetch) begin
                    irwrite_raw = 1'b1;
                    pcen_raw    = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                alusrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            EXECUTE: begin
                alusrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                alusrcA  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                pcen_raw = zero;
                state_d  = FETCH;
            end
            ADDIEX: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = FETCH;
            end
            JUMP: begin
                pcsrc    = 2'b10;
                pcen_raw = 1'b1;
                state_d  = FETCH;
            end
`ifdef MC_BNE_EN
            BNE: begin
                alusrcA  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                pcen_raw = ~zero;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // Reset only forces the state register, and FETCH itself raises
    // IRwrite/pcEn when FETCH_WAIT=0, so write enables are masked here.
    assign pcEn     = pcen_raw     & ~reset;
    assign IRwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign state    = state_q;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst0, rst3;
    logic [5:0] op, funct;
    logic       zero;

    logic       pe0, io0, mw0, ir0, rd0, mt0, rw0, sa0;
    logic [1:0] sb0, ps0;
    logic [2:0] ac0;
    logic [3:0] st0;
    logic       pe3, io3, mw3, ir3, rd3, mt3, rw3, sa3;
    logic [1:0] sb3, ps3;
    logic [2:0] ac3;
    logic [3:0] st3;

    always #5 clk = ~clk;

    mc_control #(.FETCH_WAIT(0)) u0 (
        .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
        .pcEn(pe0), .IorD(io0), .memwrite(mw0), .IRwrite(ir0),
        .regdst(rd0), .memtoreg(mt0), .regwrite(rw0), .alusrcA(sa0),
        .alusrcB(sb0), .pcsrc(ps0), .alucontrol(ac0), .state(st0)
    );

    mc_control #(.FETCH_WAIT(3)) u3 (
        .clk(clk), .reset(rst3), .op(op), .funct(funct), .zero(zero),
        .pcEn(pe3), .IorD(io3), .memwrite(mw3), .IRwrite(ir3),
        .regdst(rd3), .memtoreg(mt3), .regwrite(rw3), .alusrcA(sa3),
        .alusrcB(sb3), .pcsrc(ps3), .alucontrol(ac3), .state(st3)
    );

    logic [18:0] obs0, obs3;
    assign obs0 = {st0, pe0, io0, mw0, ir0, rd0, mt0, rw0, sa0, sb0, ps0, ac0};
    assign obs3 = {st3, pe3, io3, mw3, ir3, rd3, mt3, rw3, sa3, sb3, ps3, ac3};

    logic [18:0] exp_q[$];
    int unsigned passed = 0;
    int unsigned total  = 0;
    bit          sel    = 1'b0;

    // Expected output vector for a given state, straight from the state table.
    function automatic logic [18:0] golden(input int st, input bit lastf,
                                           input logic z, input logic [5:0] f,
                                           input bit rs);
        logic       pe, io, mw, ir, rd, mt, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic [3:0] s;
        pe = 0; io = 0; mw = 0; ir = 0; rd = 0; mt = 0; rw = 0; sa = 0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010; s = 4'(st);
        if (rs) begin
            s = 4'd0; sb = 2'b01;
        end else begin
            case (st)
                0:  begin sb = 2'b01; ir = lastf; pe = lastf; end
                1:  sb = 2'b11;
                2:  begin sa = 1; sb = 2'b10; end
                3:  io = 1;
                4:  begin mt = 1; rw = 1; end
                5:  begin io = 1; mw = 1; end
                6:  begin
                        sa = 1;
                        case (f)
                            6'b100010: ac = 3'b110;
                            6'b100100: ac = 3'b000;
                            6'b100101: ac = 3'b001;
                            6'b101010: ac = 3'b111;
                            default:   ac = 3'b010;
                        endcase
                    end
                7:  begin rd = 1; rw = 1; end
                8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
                9:  begin sa = 1; sb = 2'b10; end
                10: rw = 1;
                11: begin ps = 2'b10; pe = 1; end
                12: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = ~z; end
                default: ;
            endcase
        end
        return {s, pe, io, mw, ir, rd, mt, rw, sa, sb, ps, ac};
    endfunction

    // Push the expectation for the current cycle, sample mid-cycle, compare,
    // then move on to the next falling edge.
    task automatic step(input string tag, input int st, input bit lastf, input bit rs);
        logic [18:0] got, e;
        exp_q.push_back(golden(st, lastf, zero, funct, rs));
        #1;
        got = sel ? obs3 : obs0;
        e = exp_q.pop_front();
        total++;
        assert (got === e) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        op = 6'b000000; funct = 6'b000000; zero = 1'b0;
        @(negedge clk); @(negedge clk);
        step("reset0", 0, 0, 1);

        rst0 = 1'b0;
        // lw
        op = 6'b100011;
        step("lw_f", 0, 1, 0); step("lw_d", 1, 0, 0); step("lw_adr", 2, 0, 0);
        step("lw_rd", 3, 0, 0); step("lw_wb", 4, 0, 0);
        // sw
        op = 6'b101011;
        step("sw_f", 0, 1, 0); step("sw_d", 1, 0, 0); step("sw_adr", 2, 0, 0);
        step("sw_wr", 5, 0, 0);
        // R-type: slt, add, sub, and, or, unknown funct
        op = 6'b000000;
        funct = 6'b101010;
        step("slt_f", 0, 1, 0); step("slt_d", 1, 0, 0); step("slt_ex", 6, 0, 0); step("slt_wb", 7, 0, 0);
        funct = 6'b100000;
        step("add_f", 0, 1, 0); step("add_d", 1, 0, 0); step("add_ex", 6, 0, 0); step("add_wb", 7, 0, 0);
        funct = 6'b100010;
        step("sub_f", 0, 1, 0); step("sub_d", 1, 0, 0); step("sub_ex", 6, 0, 0); step("sub_wb", 7, 0, 0);
        funct = 6'b100100;
        step("and_f", 0, 1, 0); step("and_d", 1, 0, 0); step("and_ex", 6, 0, 0); step("and_wb", 7, 0, 0);
        funct = 6'b100101;
        step("or_f", 0, 1, 0); step("or_d", 1, 0, 0); step("or_ex", 6, 0, 0); step("or_wb", 7, 0, 0);
        funct = 6'b111111;
        step("fx_f", 0, 1, 0); step("fx_d", 1, 0, 0); step("fx_ex", 6, 0, 0); step("fx_wb", 7, 0, 0);
        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        step("beq1_f", 0, 1, 0); step("beq1_d", 1, 0, 0); step("beq1_br", 8, 0, 0);
        zero = 1'b0;
        step("beq0_f", 0, 1, 0); step("beq0_d", 1, 0, 0); step("beq0_br", 8, 0, 0);
        // addi
        op = 6'b001000;
        step("addi_f", 0, 1, 0); step("addi_d", 1, 0, 0); step("addi_ex", 9, 0, 0); step("addi_wb", 10, 0, 0);
        // j
        op = 6'b000010;
        step("j_f", 0, 1, 0); step("j_d", 1, 0, 0); step("j_j", 11, 0, 0);
        // unknown op
        op = 6'b111111;
        step("unk_f", 0, 1, 0); step("unk_d", 1, 0, 0);
        // bne
        op = 6'b000101; zero = 1'b0;
`ifdef MC_BNE_EN
        step("bne0_f", 0, 1, 0); step("bne0_d", 1, 0, 0); step("bne0_b", 12, 0, 0);
        zero = 1'b1;
        step("bne1_f", 0, 1, 0); step("bne1_d", 1, 0, 0); step("bne1_b", 12, 0, 0);
`else
        step("bne_f", 0, 1, 0); step("bne_d", 1, 0, 0);
`endif
        zero = 1'b0;
        step("post_f", 0, 1, 0);

        // reset mid-instruction on the FETCH_WAIT=0 instance
        op = 6'b100011;
        step("r0_d", 1, 0, 0); step("r0_adr", 2, 0, 0);
        #2 rst0 = 1'b1;
        step("r0_async", 0, 0, 1);
        step("r0_hold", 0, 0, 1);
        rst0 = 1'b0;
        step("r0_f", 0, 1, 0); step("r0_d2", 1, 0, 0);

        // FETCH_WAIT=3 instance
        rst0 = 1'b1;
        sel = 1'b1;
        step("reset3", 0, 0, 1);
        rst3 = 1'b0;
        op = 6'b100011;
        step("w3_f0", 0, 0, 0); step("w3_f1", 0, 0, 0); step("w3_f2", 0, 0, 0);
        step("w3_f3", 0, 1, 0); step("w3_d", 1, 0, 0); step("w3_adr", 2, 0, 0);
        step("w3_rd", 3, 0, 0);
        rst3 = 1'b1;
        step("w3_rst", 0, 0, 1);
        rst3 = 1'b0;
        step("w3_g0", 0, 0, 0); step("w3_g1", 0, 0, 0); step("w3_g2", 0, 0, 0);
        step("w3_g3", 0, 1, 0); step("w3_gd", 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter FETCH_WAIT, default 0, meaning extra memory wait cycles held in FETCH (range 0..7).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have ports op and funct, input, 6 each, instruction fields [31:26] and [5:0].
REQ-005 SHALL have port zero, input, 1, ALU zero flag from the datapath.
REQ-006 SHALL have outputs pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite and alusrcA, 1 each, datapath controls.
REQ-007 SHALL have outputs alusrcB and pcsrc, 2 each, and alucontrol, 3, datapath mux selects and ALU op.
REQ-008 SHALL have output state, 4, current FSM state for debug.

Function
REQ-009 SHALL be a Moore FSM; all outputs decode from state only, except pcEn in BRANCH/BNE (zero-dependent).
REQ-010 SHALL use states and codes FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12.
REQ-011 FETCH: IorD=0, alusrcA=0, alusrcB=01, alucontrol=010, pcsrc=00; IRwrite and pcEn asserted only on the final FETCH cycle.
REQ-012 SHALL hold FETCH for FETCH_WAIT+1 cycles using a 3-bit wait counter, cleared on FETCH exit.
REQ-013 DECODE: alusrcA=0, alusrcB=11, alucontrol=010 (branch target into aluout).
REQ-014 DECODE next state by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other op -> FETCH with no write enable asserted.
REQ-015 MEMADR: alusrcA=1, alusrcB=10, alucontrol=010; next MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD: IorD=1 -> MEMWB; MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-017 MEMWR: IorD=1, memwrite=1 -> FETCH.
REQ-018 EXECUTE: alusrcA=1, alusrcB=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, others->010.
REQ-019 ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-020 BRANCH: alusrcA=1, alusrcB=00, alucontrol=110, pcsrc=01, pcEn=zero -> FETCH.
REQ-021 ADDIEX: alusrcA=1, alusrcB=10, alucontrol=010 -> ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-022 JUMP: pcsrc=10, pcEn=1 -> FETCH.
REQ-023 Outputs not listed for a state SHALL be 0 (selects 00, alucontrol 010).
REQ-024 Exactly one of {pcEn on a non-FETCH state, regwrite, memwrite} SHALL be asserted per instruction at most; no write enable SHALL ever be X.

Reset
REQ-025 Reset SHALL asynchronously force state=FETCH and wait counter=0.
REQ-026 While reset is high pcEn, IRwrite, regwrite, memwrite SHALL be 0; other outputs SHALL show FETCH values.
REQ-027 Reset mid-instruction SHALL abandon it; first cycle after release is FETCH cycle 0.

Configuration
REQ-028 Macro MC_BNE_EN: when defined, op 000101 in DECODE -> BNE (as BRANCH but pcEn=~zero) -> FETCH.
REQ-029 Without MC_BNE_EN, op 000101 SHALL take the unknown-op path (REQ-014) and state code 12 SHALL be unreachable.

Structure
REQ-030 Package mc_pkg SHALL hold the state enum, opcode and funct constants, and alucontrol encodings.
REQ-031 Sub-module mc_aludec SHALL map (aluop 2 bits, funct) to alucontrol; FSM drives aluop 00 add, 01 sub, 10 funct.

Verification
REQ-032 FETCH_WAIT=0, reset released, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-033 op=101011 -> states 0,1,2,5,0; memwrite=1 with IorD=1 only in state 5; regwrite never 1.
REQ-034 op=000000 funct=101010 -> EXECUTE alucontrol=111, ALUWB regdst=1 regwrite=1.
REQ-035 op=000100 with zero=1 then zero=0 -> pcEn=1 then 0 in BRANCH, pcsrc=01 both times.
REQ-036 FETCH_WAIT=3 -> FETCH held 4 cycles, IRwrite/pcEn high only on 4th; reset pulsed in MEMRD -> next cycle FETCH, no regwrite.
REQ-037 op=000101 -> with MC_BNE_EN, state 12 and pcEn=~zero; without it, 0,1,0 with no write enables.
